// File: rtl/fball_pkg.sv
// Shared types and constants for the fireball sprite scheduler.
// The animation feature is enabled by defining FBALL_ANIM_EN.
package fball_pkg;

    typedef enum logic [1:0] {
        FB_DOWN  = 2'd0,
        FB_LEFT  = 2'd1,
        FB_UP    = 2'd2,
        FB_RIGHT = 2'd3
    } fb_orient_t;

    localparam int          FB_SPRITE_W    = 21;
    localparam int          FB_SPRITE_H    = 21;
    localparam int          FB_ROM_DEPTH   = 441;
    localparam logic [11:0] FB_TRANSPARENT = 12'h808;

    // Per-slot phase offset so neighbouring fireballs spin out of step.
    function automatic fb_orient_t slot_orient(input fb_orient_t base, input logic [1:0] idx);
        logic [1:0] sum;
        sum = 2'(base) + idx;
        return fb_orient_t'(sum);
    endfunction

endpackage

// File: rtl/fball_anim_fsm.sv
// Frame-rate divider and orientation FSM for the fireball spin animation.
// Instantiated by fball_sprite_sched only when FBALL_ANIM_EN is defined.
module fball_anim_fsm
    import fball_pkg::*;
#(
    parameter int ANIM_DIV = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    output fb_orient_t orient
);

    fb_orient_t r_state;
    fb_orient_t w_state_next;
    logic [7:0] r_anim_cnt;
    logic [7:0] w_cnt_next;

    // State and divider registers; reset dominates any coincident strobe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= FB_DOWN;
            r_anim_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_anim_cnt <= w_cnt_next;
        end
    end

    // Count strobes; on the last one of a period, wrap and step the orientation.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_anim_cnt;
        if (frame_start) begin
            if (r_anim_cnt == 8'(ANIM_DIV - 1)) begin
                w_cnt_next = 8'd0;
                case (r_state)
                    FB_DOWN:  w_state_next = FB_LEFT;
                    FB_LEFT:  w_state_next = FB_UP;
                    FB_UP:    w_state_next = FB_RIGHT;
                    FB_RIGHT: w_state_next = FB_DOWN;
                    default:  w_state_next = FB_DOWN;
                endcase
            end else begin
                w_cnt_next = r_anim_cnt + 8'd1;
            end
        end
    end

    assign orient = r_state;

endmodule

// File: rtl/fball_sprite_sched.sv
// Fireball sprite scheduler: per-pixel hit test over NUM_BALLS slots,
// lowest-index priority, shared orientation-ROM addressing and a
// two-stage pipeline producing a transparency-qualified colour.
// Define FBALL_ANIM_EN to enable the spinning animation; without it
// every slot uses the "down" ROM and frame_start is ignored.
module fball_sprite_sched
    import fball_pkg::*;
#(
    parameter int NUM_BALLS = 4,
    parameter int ANIM_DIV  = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_start,
    input  logic [NUM_BALLS-1:0]      ball_active,
    input  logic [NUM_BALLS-1:0][9:0] ball_x,
    input  logic [NUM_BALLS-1:0][9:0] ball_y,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    output logic [8:0]                rom_addr,
    output logic [1:0]                rom_sel,
    input  logic [11:0]               rom_color,
    output logic                      pixel_valid,
    output logic [11:0]               pixel_color,
    output logic [2:0]                pixel_id
);

`ifdef FBALL_ANIM_EN
    fb_orient_t w_orient;

    fball_anim_fsm #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .orient      (w_orient)
    );
`else
    logic w_unused_frame_start;
    assign w_unused_frame_start = frame_start;
`endif

    logic [NUM_BALLS-1:0] w_hit;

    // Per-slot bounding-box test; right/bottom edges are formed at 11 bits
    // so a sprite near X=1023 cannot wrap around to column 0.
    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_slot
        logic [10:0] w_x_end;
        logic [10:0] w_y_end;
        assign w_x_end = {1'b0, ball_x[g]} + 11'(FB_SPRITE_W);
        assign w_y_end = {1'b0, ball_y[g]} + 11'(FB_SPRITE_H);
        assign w_hit[g] = ball_active[g]
                        && (DrawX >= ball_x[g]) && ({1'b0, DrawX} < w_x_end)
                        && (DrawY >= ball_y[g]) && ({1'b0, DrawY} < w_y_end);
    end

    logic       w_any;
    logic [2:0] w_win;
    logic [9:0] w_bx;
    logic [9:0] w_by;
    fb_orient_t w_sel;
    logic [4:0] w_dx;
    logic [4:0] w_dy;
    logic [8:0] w_addr;

    // Priority encode (lowest index wins) and form the in-sprite ROM address.
    always_comb begin
        w_any = 1'b0;
        w_win = 3'd0;
        w_bx  = 10'd0;
        w_by  = 10'd0;
        w_sel = FB_DOWN;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any = 1'b1;
                w_win = 3'(i);
                w_bx  = ball_x[i];
                w_by  = ball_y[i];
`ifdef FBALL_ANIM_EN
                w_sel = slot_orient(w_orient, 2'(i));
`else
                w_sel = FB_DOWN;
`endif
            end
        end
        w_dx   = 5'(DrawX - w_bx);
        w_dy   = 5'(DrawY - w_by);
        w_addr = w_any ? (9'(w_dy) * 9'(FB_SPRITE_W) + 9'(w_dx)) : 9'd0;
    end

    // ---- stage boundary p0 -> p1: address/select to ROM, hit/id delayed ----
    logic [8:0] r_addr_p1;
    fb_orient_t r_sel_p1;
    logic       r_hit_p1;
    logic [2:0] r_id_p1;

    // Register the hit-test result that addresses the shared ROM.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_addr_p1 <= 9'd0;
            r_sel_p1  <= FB_DOWN;
            r_hit_p1  <= 1'b0;
            r_id_p1   <= 3'd0;
        end else begin
            r_addr_p1 <= w_addr;
            r_sel_p1  <= w_sel;
            r_hit_p1  <= w_any;
            r_id_p1   <= w_win;
        end
    end

    assign rom_addr = r_addr_p1;
    assign rom_sel  = r_sel_p1;

    // ---- stage boundary p1 -> p2: qualify ROM colour against the key ----
    logic        w_opaque;
    logic        r_vld_p2;
    logic [11:0] r_color_p2;
    logic [2:0]  r_id_p2;

    assign w_opaque = r_hit_p1 && (rom_color != FB_TRANSPARENT);

    // Register the final pixel; colour is zeroed whenever it is not opaque.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_vld_p2   <= 1'b0;
            r_color_p2 <= 12'd0;
            r_id_p2    <= 3'd0;
        end else begin
            r_vld_p2   <= w_opaque;
            r_color_p2 <= w_opaque ? rom_color : 12'd0;
            r_id_p2    <= r_id_p1;
        end
    end

    assign pixel_valid = r_vld_p2;
    assign pixel_color = r_color_p2;
    assign pixel_id    = r_id_p2;

endmodule

// File: tb/tb_fball_sprite_sched.sv
// Self-checking bench for fball_sprite_sched (works with or without FBALL_ANIM_EN).
module tb_fball_sprite_sched;

    localparam int NB  = 4;
    localparam int DIV = 3;
    localparam int NSTREAM = 200;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              frame_start;
    logic [NB-1:0]     ball_active;
    logic [NB-1:0][9:0] ball_x;
    logic [NB-1:0][9:0] ball_y;
    logic [9:0]        DrawX, DrawY;
    logic [8:0]        rom_addr;
    logic [1:0]        rom_sel;
    logic [11:0]       rom_color;
    logic              pixel_valid;
    logic [11:0]       pixel_color;
    logic [2:0]        pixel_id;

    int errors = 0;
    int checks = 0;

    // model state
    int act [NB];
    int bx  [NB];
    int by  [NB];
    int strobes = 0;

    always #5 Clk = ~Clk;

    fball_sprite_sched #(.NUM_BALLS(NB), .ANIM_DIV(DIV)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .ball_active(ball_active), .ball_x(ball_x), .ball_y(ball_y),
        .DrawX(DrawX), .DrawY(DrawY),
        .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_color(rom_color),
        .pixel_valid(pixel_valid), .pixel_color(pixel_color), .pixel_id(pixel_id)
    );

    // ROM model: transparent key at addresses 0 and 100, otherwise a unique colour.
    function automatic logic [11:0] rom_model(input int a, input int s);
        logic [8:0] a9;
        logic [1:0] s2;
        a9 = 9'(a);
        s2 = 2'(s);
        if (a == 0 || a == 100) return 12'h808;
        return {s2, 1'b1, a9};
    endfunction

    assign rom_color = rom_model(int'(rom_addr), int'(rom_sel));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_orient();
`ifdef FBALL_ANIM_EN
        return (strobes / DIV) % 4;
`else
        return 0;
`endif
    endfunction

    // Reference: returns what the pipeline should produce for pixel (px,py).
    task automatic model(input int px, input int py, output int hit, output int id,
                         output int addr, output int sel, output int vld, output int col);
        int c;
        hit = 0; id = 0; addr = 0; sel = 0;
        for (int i = 0; i < NB; i++) begin
            if (hit == 0 && act[i] != 0 && px >= bx[i] && px < bx[i] + 21
                && py >= by[i] && py < by[i] + 21) begin
                hit  = 1;
                id   = i;
                addr = (py - by[i]) * 21 + (px - bx[i]);
`ifdef FBALL_ANIM_EN
                sel  = (model_orient() + i) % 4;
`else
                sel  = 0;
`endif
            end
        end
        c   = rom_model(addr, sel);
        vld = (hit != 0 && c != 12'h808) ? 1 : 0;
        col = vld ? int'(c) : 0;
    endtask

    task automatic load_balls();
        for (int i = 0; i < NB; i++) begin
            ball_active[i] = (act[i] != 0);
            ball_x[i] = 10'(bx[i]);
            ball_y[i] = 10'(by[i]);
        end
    endtask

    // Single pixel through the pipeline with checks at cycle 1 and cycle 2.
    task automatic probe(input string tag, input int px, input int py);
        int h, id, a, s, v, c;
        @(negedge Clk);
        DrawX = 10'(px);
        DrawY = 10'(py);
        model(px, py, h, id, a, s, v, c);
        @(posedge Clk); #1;
        check({tag, ".addr"}, 32'(rom_addr), 32'(a));
        check({tag, ".sel"},  32'(rom_sel),  32'(s));
        @(posedge Clk); #1;
        check({tag, ".valid"}, 32'(pixel_valid), 32'(v));
        check({tag, ".color"}, 32'(pixel_color), 32'(c));
        if (h != 0) check({tag, ".id"}, 32'(pixel_id), 32'(id));
    endtask

    task automatic strobe();
        @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        strobes++;
    endtask

    int s_addr [NSTREAM];
    int s_sel  [NSTREAM];
    int s_vld  [NSTREAM];
    int s_col  [NSTREAM];
    int s_id   [NSTREAM];
    int s_hit  [NSTREAM];
    int seq_exp [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};

    initial begin
        Reset = 1'b1;
        frame_start = 1'b1;          // coincident with reset: must be discarded
        DrawX = 10'd0; DrawY = 10'd0;
        for (int i = 0; i < NB; i++) begin act[i] = 0; bx[i] = 0; by[i] = 0; end
        load_balls();
        repeat (3) @(posedge Clk);
        #1;
        check("rst.valid", 32'(pixel_valid), 32'd0);
        check("rst.addr",  32'(rom_addr),    32'd0);
        check("rst.sel",   32'(rom_sel),     32'd0);
        check("rst.id",    32'(pixel_id),    32'd0);
        check("rst.color", 32'(pixel_color), 32'd0);
        @(negedge Clk);
        frame_start = 1'b0;
        Reset = 1'b0;

        // Single hit
        act[0] = 1; bx[0] = 100; by[0] = 50;
        load_balls();
        @(negedge Clk);
        DrawX = 10'd110; DrawY = 10'd60;
        @(posedge Clk); #1;
        check("single.addr220", 32'(rom_addr), 32'd220);
        @(posedge Clk); #1;
        check("single.valid", 32'(pixel_valid), 32'd1);
        check("single.color", 32'(pixel_color), 32'(rom_model(220, 0)));
        check("single.id",    32'(pixel_id),    32'd0);
        probe("single", 110, 60);

        // Overlap and edges
        act[1] = 1; bx[1] = 200; by[1] = 200;
        act[2] = 1; bx[2] = 200; by[2] = 200;
        act[3] = 1; bx[3] = 1015; by[3] = 300;
        load_balls();
        probe("overlap", 205, 205);
        check("overlap.id1", 32'(pixel_id), 32'd1);
        probe("edge_right", 221, 200);
        check("edge_right.miss", 32'(pixel_valid), 32'd0);
        probe("edge_last", 220, 220);
        probe("wrap", 5, 305);
        check("wrap.miss", 32'(pixel_valid), 32'd0);
        probe("far_right", 1020, 305);

        // Transparency at top-left corner
        probe("transp", 100, 50);
        check("transp.valid", 32'(pixel_valid), 32'd0);
        check("transp.color", 32'(pixel_color), 32'd0);

        // Animation: slot 0 and slot 1 select across 20 strobes
        for (int k = 0; k <= 20; k++) begin
            probe("anim0", 110, 60);
`ifdef FBALL_ANIM_EN
            if (k < 13) check("anim0.seq", 32'(rom_sel), 32'(seq_exp[k]));
`else
            check("anim0.zero", 32'(rom_sel), 32'd0);
`endif
            probe("anim1", 205, 205);
            if (k < 20) strobe();
        end

        // Randomised streaming at one pixel per cycle
        for (int i = 0; i < NB; i++) begin
            act[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
            bx[i]  = $urandom_range(0, 1023);
            by[i]  = $urandom_range(0, 479);
        end
        act[0] = 1; bx[0] = 1010;
        act[1] = 1; bx[1] = bx[2] + 7; by[1] = by[2] + 5;
        load_balls();
        for (int k = 0; k <= NSTREAM; k++) begin
            @(negedge Clk);
            if (k < NSTREAM) begin
                int j, px, py, h, id, a, s, v, c;
                j  = $urandom_range(0, NB - 1);
                px = (bx[j] + $urandom_range(0, 25) - 2) & 1023;
                py = (by[j] + $urandom_range(0, 25) - 2) & 1023;
                DrawX = 10'(px);
                DrawY = 10'(py);
                model(px, py, h, id, a, s, v, c);
                s_hit[k] = h; s_id[k] = id; s_addr[k] = a;
                s_sel[k] = s; s_vld[k] = v; s_col[k] = c;
            end
            @(posedge Clk); #1;
            if (k < NSTREAM) begin
                check("stream.addr", 32'(rom_addr), 32'(s_addr[k]));
                check("stream.sel",  32'(rom_sel),  32'(s_sel[k]));
            end
            if (k >= 1) begin
                check("stream.valid", 32'(pixel_valid), 32'(s_vld[k-1]));
                check("stream.color", 32'(pixel_color), 32'(s_col[k-1]));
                if (s_hit[k-1] != 0) check("stream.id", 32'(pixel_id), 32'(s_id[k-1]));
            end
        end

        // Asynchronous reset mid-stream with a live hit in the pipe
        act[0] = 1; bx[0] = 100; by[0] = 50;
        act[1] = 1; bx[1] = 200; by[1] = 200;
        load_balls();
        @(negedge Clk);
        DrawX = 10'd210; DrawY = 10'd210;   // slot 1, nonzero address
        @(posedge Clk); @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check("arst.valid", 32'(pixel_valid), 32'd0);
        check("arst.addr",  32'(rom_addr),    32'd0);
        check("arst.sel",   32'(rom_sel),     32'd0);
        check("arst.id",    32'(pixel_id),    32'd0);
        strobes = 0;
        @(negedge Clk);
        Reset = 1'b0;
        probe("post_rst", 110, 60);
        check("post_rst.sel0", 32'(rom_sel), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
